// File: rtl/mem_pkg.sv
// Shared types and RV32I load/store encodings for the byte-addressed data memory.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {StClear, StIdle, StWait} state_e;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  function automatic be_t store_be(logic [2:0] size, logic [1:0] off);
    be_t be;
    case (size)
      F3_B:    be = be_t'(4'b0001 << off);
      F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the low bytes so every enabled lane sees its data at its own position.
  function automatic word_t store_lanes(logic [2:0] size, word_t wdata);
    word_t lanes;
    case (size)
      F3_B:    lanes = {4{wdata[7:0]}};
      F3_H:    lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Lane select plus sign/zero extension of a 32-bit memory word for RV32I loads.
module dmem_load_align
  import mem_pkg::*;
(
  input  word_t      word_i,
  input  logic [1:0] off_i,
  input  logic [2:0] size_i,
  output word_t      data_o
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b  = word_i[{off_i, 3'b000} +: 8];
    sel_h  = off_i[1] ? word_i[31:16] : word_i[15:0];
    data_o = '0;
    case (size_i)
      F3_B:    data_o = {{24{sel_b[7]}}, sel_b};
      F3_H:    data_o = {{16{sel_h[15]}}, sel_h};
      F3_W:    data_o = word_i;
      F3_BU:   data_o = {24'b0, sel_b};
      F3_HU:   data_o = {16'b0, sel_h};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory with an RV32I load/store front end, post-reset clear
// and access-fault reporting.
module data_memory_lsu
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 64,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [2:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        init_done_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  word_t mem_q [DEPTH_WORDS];

  state_e        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          init_done_q, init_done_d;
  logic          rsp_valid_q, rsp_valid_d;
  word_t         rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  word_t         pend_q, pend_d;

  logic [AW-1:0] word_idx;
  word_t         rd_word, load_data;
  logic          size_ok, misalign, out_of_range, req_err, accept;
  logic          clr_we, st_we;
  be_t           st_be;
  word_t         st_data;

  assign word_idx = req_addr_i[AW+1:2];
  assign rd_word  = mem_q[word_idx];
  assign st_be    = store_be(req_size_i, req_addr_i[1:0]);
  assign st_data  = store_lanes(req_size_i, req_wdata_i);

  dmem_load_align u_load_align (
    .word_i (rd_word),
    .off_i  (req_addr_i[1:0]),
    .size_i (req_size_i),
    .data_o (load_data)
  );

  always_comb begin
    size_ok = 1'b0;
    case (req_size_i)
      F3_B, F3_H, F3_W: size_ok = 1'b1;
      F3_BU, F3_HU:     size_ok = ~req_write_i;
      default:          size_ok = 1'b0;
    endcase
    misalign     = (((req_size_i == F3_H) || (req_size_i == F3_HU)) && req_addr_i[0]) ||
                   ((req_size_i == F3_W) && (req_addr_i[1:0] != 2'b00));
    out_of_range = req_addr_i[31:2] >= 30'(DEPTH_WORDS);
    req_err      = ~size_ok | misalign | out_of_range;
  end

  assign req_ready_o = (state_q == StIdle) && init_done_q;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    pend_d      = pend_q;
    clr_we      = 1'b0;
    st_we       = 1'b0;

    unique case (state_q)
      StClear: begin
        clr_we = 1'b1;
        if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      StIdle: begin
        // Only reachable with init_done low when the clear sequence is disabled.
        if (!init_done_q) begin
          init_done_d = 1'b1;
        end else if (accept) begin
          if (req_err || req_write_i) begin
            st_we       = ~req_err;
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
            rsp_rdata_d = '0;
          end else if (READ_LATENCY == 1) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = load_data;
          end else begin
            pend_d  = load_data;
            cnt_d   = 2'(READ_LATENCY - 2);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pend_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= CLEAR_ON_RESET ? StClear : StIdle;
      clr_idx_q   <= '0;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      pend_q      <= pend_d;
    end
  end

  // The array has no reset; contents survive reset and are only zeroed by the clear walk.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem_q[clr_idx_q] <= '0;
    end else if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem_q[word_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Randomized bench for data_memory_lsu: four instances (latency 1/3/4 with clear, latency 2
// without) checked against a byte-array reference model.
module tb_data_memory_lsu;
  import mem_pkg::*;

  localparam int NI = 4;
  localparam int DW = 64;

  function automatic int unsigned lat_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : (k == 2) ? 4 : 2;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_n, req_valid, req_ready, req_write, rsp_valid, rsp_err, init_done;
  logic [31:0]   req_addr  [NI];
  logic [2:0]    req_size  [NI];
  logic [31:0]   req_wdata [NI];
  logic [31:0]   rsp_rdata [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_memory_lsu #(
      .DEPTH_WORDS    (DW),
      .READ_LATENCY   (lat_of(g)),
      .CLEAR_ON_RESET (g != 3)
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n[g]),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_write_i (req_write[g]),
      .req_addr_i  (req_addr[g]),
      .req_size_i  (req_size[g]),
      .req_wdata_i (req_wdata[g]),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_rdata_o (rsp_rdata[g]),
      .rsp_err_o   (rsp_err[g]),
      .init_done_o (init_done[g])
    );
  end

  bit   [7:0]  mm [NI][256];
  logic [31:0] last_rd [NI];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte array, access width from funct3, fault rules applied directly to the address.
  function automatic void model(input int k, input bit w, input logic [31:0] a,
                                input logic [2:0] s, input logic [31:0] d,
                                output bit err, output logic [31:0] rd);
    int nb;
    int ai;
    bit legal;
    case (s)
      3'd0, 3'd1, 3'd2: legal = 1'b1;
      3'd4, 3'd5:       legal = !w;
      default:          legal = 1'b0;
    endcase
    nb  = (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : 4;
    err = !legal || ((a % nb) != 0) || (a >= 32'(DW * 4));
    rd  = '0;
    if (err) return;
    ai = int'(a[7:0]);
    if (w) begin
      for (int i = 0; i < nb; i++) mm[k][ai+i] = d[8*i +: 8];
    end else begin
      for (int i = 0; i < nb; i++) rd = rd | (32'(mm[k][ai+i]) << (8 * i));
      if (!s[2] && nb < 4 && rd[8*nb-1]) rd = rd | ~((32'd1 << (8 * nb)) - 32'd1);
    end
  endfunction

  task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [2:0] s,
                       input logic [31:0] d, output logic [31:0] obs);
    bit          e;
    logic [31:0] r;
    int          lat;
    int          n;
    @(negedge clk);
    check("idle_valid", 32'(rsp_valid[k]), 32'd0);
    check("hold_rdata", rsp_rdata[k], last_rd[k]);
    req_write[k] = w;
    req_addr[k]  = a;
    req_size[k]  = s;
    req_wdata[k] = d;
    req_valid[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 32'(n), 32'd0);
    model(k, w, a, s, d, e, r);
    lat = (e || w) ? 1 : int'(lat_of(k));
    @(posedge clk);
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      if (c == 0) req_valid[k] = 1'b0;
      if (c < lat - 1) begin
        check("wait_valid", 32'(rsp_valid[k]), 32'd0);
        check("wait_ready", 32'(req_ready[k]), 32'd0);
      end
    end
    check("rsp_valid", 32'(rsp_valid[k]), 32'd1);
    check("rsp_ready", 32'(req_ready[k]), 32'd1);
    check("rsp_err", 32'(rsp_err[k]), 32'(e));
    check("rsp_rdata", rsp_rdata[k], r);
    obs        = rsp_rdata[k];
    last_rd[k] = r;
  endtask

  task automatic wait_init(input int k, output int n, output int pulses);
    int bad_ready;
    n = 0;
    pulses = 0;
    bad_ready = 0;
    while (!init_done[k] && n < 300) begin
      if (req_ready[k]) bad_ready++;
      pulses += int'(rsp_valid[k]);
      @(negedge clk);
      n++;
    end
    check("clr_ready_low", 32'(bad_ready), 32'd0);
    check("clr_ready_after", 32'(req_ready[k]), 32'd1);
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_flags", 32'({init_done[k], req_ready[k], rsp_valid[k], rsp_err[k]}), 32'd0);
    check("rst_rdata", rsp_rdata[k], 32'd0);
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] a;
    int          n, p;

    rst_n     = '0;
    req_valid = '0;
    req_write = '0;
    for (int k = 0; k < NI; k++) begin
      req_addr[k]  = '0;
      req_size[k]  = '0;
      req_wdata[k] = '0;
      last_rd[k]   = '0;
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) check_reset_outputs(k);
    rst_n = '1;
    @(negedge clk);
    check("noclr_init", 32'(init_done[3]), 32'd1);
    check("noclr_ready", 32'(req_ready[3]), 32'd1);
    check("clr_init_early", 32'(init_done[0]), 32'd0);
    wait_init(0, n, p);
    check("clr_edges", 32'(n + 1), 32'd64);

    // The no-clear instance starts with unknown contents; zero it through the port.
    for (int i = 0; i < DW; i++) issue(3, 1'b1, 32'(4 * i), F3_W, 32'd0, obs);

    issue(0, 1'b0, 32'h00, F3_W, 32'd0, obs);
    check("lw00_zero", obs, 32'h0);
    issue(0, 1'b0, 32'hFC, F3_W, 32'd0, obs);
    check("lwfc_zero", obs, 32'h0);
    issue(0, 1'b1, 32'h10, F3_W, 32'hDEADBEEF, obs);
    issue(0, 1'b1, 32'h11, F3_B, 32'h000000A5, obs);
    issue(0, 1'b0, 32'h10, F3_W, 32'd0, obs);
    check("lw10", obs, 32'hDEADA5EF);
    issue(0, 1'b0, 32'h11, F3_B, 32'd0, obs);
    check("lb11", obs, 32'hFFFFFFA5);
    issue(0, 1'b0, 32'h11, F3_BU, 32'd0, obs);
    check("lbu11", obs, 32'h000000A5);
    issue(0, 1'b0, 32'h12, F3_HU, 32'd0, obs);
    check("lhu12", obs, 32'h0000DEAD);
    issue(0, 1'b0, 32'h13, F3_W, 32'd0, obs);
    check("err_lw13", {31'd0, rsp_err[0]}, 32'd1);
    issue(0, 1'b1, 32'h101, F3_H, 32'hFFFF, obs);
    issue(0, 1'b0, 32'h100, F3_W, 32'd0, obs);
    check("err_oor", {31'd0, rsp_err[0]}, 32'd1);
    issue(0, 1'b1, 32'h10, 3'd4, 32'hFFFFFFFF, obs);
    check("err_f3_4", {31'd0, rsp_err[0]}, 32'd1);
    issue(0, 1'b0, 32'h10, F3_W, 32'd0, obs);
    check("lw10_after_err", obs, 32'hDEADA5EF);

    // Latency 3: LH accepted at N, an early LW must wait until edge N+3.
    issue(1, 1'b1, 32'h10, F3_W, 32'hDEADBEEF, obs);
    @(negedge clk);
    req_write[1] = 1'b0;
    req_addr[1]  = 32'h12;
    req_size[1]  = F3_H;
    req_valid[1] = 1'b1;
    check("l3_ready_pre", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_addr[1] = 32'h10;
    req_size[1] = F3_W;
    check("l3_n1_ready", 32'(req_ready[1]), 32'd0);
    check("l3_n1_valid", 32'(rsp_valid[1]), 32'd0);
    @(negedge clk);
    check("l3_n2_ready", 32'(req_ready[1]), 32'd0);
    check("l3_n2_valid", 32'(rsp_valid[1]), 32'd0);
    @(negedge clk);
    check("l3_rsp_valid", 32'(rsp_valid[1]), 32'd1);
    check("l3_rsp_ready", 32'(req_ready[1]), 32'd1);
    check("l3_rsp_rdata", rsp_rdata[1], 32'hFFFFDEAD);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("l3_second_taken", 32'(req_ready[1]), 32'd0);
    check("l3_single_pulse", 32'(rsp_valid[1]), 32'd0);
    @(negedge clk);
    check("l3_second_wait", 32'(rsp_valid[1]), 32'd0);
    @(negedge clk);
    check("l3_second_valid", 32'(rsp_valid[1]), 32'd1);
    check("l3_second_rdata", rsp_rdata[1], 32'hDEADBEEF);
    last_rd[1] = 32'hDEADBEEF;

    // Back-to-back store then load at latency 1.
    @(negedge clk);
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h20;
    req_size[0]  = F3_W;
    req_wdata[0] = 32'h12345678;
    req_valid[0] = 1'b1;
    check("b2b_ready0", 32'(req_ready[0]), 32'd1);
    model(0, 1'b1, 32'h20, F3_W, 32'h12345678, p[0], obs);
    @(negedge clk);
    check("b2b_st_valid", 32'(rsp_valid[0]), 32'd1);
    check("b2b_st_rdata", rsp_rdata[0], 32'd0);
    check("b2b_ready1", 32'(req_ready[0]), 32'd1);
    req_write[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("b2b_ld_valid", 32'(rsp_valid[0]), 32'd1);
    check("b2b_ld_rdata", rsp_rdata[0], 32'h12345678);
    last_rd[0] = 32'h12345678;

    for (int k = 0; k < NI; k++) begin
      repeat (150) begin
        if ($urandom_range(0, 9) == 0) a = $urandom;
        else a = 32'($urandom_range(0, 255));
        issue(k, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom, obs);
      end
    end

    // Reset in the middle of a latency-4 load: the response must never appear.
    @(negedge clk);
    req_write[2] = 1'b0;
    req_addr[2]  = 32'h0;
    req_size[2]  = F3_W;
    req_valid[2] = 1'b1;
    check("drop_ready", 32'(req_ready[2]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    check_reset_outputs(2);
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    wait_init(2, n, p);
    check("drop_pulses", 32'(p), 32'd0);
    check("clr_edges_r1", 32'(n), 32'd64);
    last_rd[2] = '0;

    // Reset while the clear walk is at index 30 must restart it from index 0.
    issue(2, 1'b1, 32'h00, F3_W, 32'h11111111, obs);
    issue(2, 1'b1, 32'hA0, F3_W, 32'h22222222, obs);
    @(negedge clk);
    rst_n[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    repeat (30) @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    check_reset_outputs(2);
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    wait_init(2, n, p);
    check("clr_edges_r2", 32'(n), 32'd64);
    for (int i = 0; i < 256; i++) mm[2][i] = 8'd0;
    last_rd[2] = '0;
    issue(2, 1'b0, 32'h00, F3_W, 32'd0, obs);
    check("cleared_w0", obs, 32'd0);
    issue(2, 1'b0, 32'hA0, F3_W, 32'd0, obs);
    check("cleared_w40", obs, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
